btn_sense: RTL and testbench

Debounced push-button input block: the input-side counterpart of the LED blinker output. It synchronises a raw, bouncing button line into `m_clock`, filters it with a stability counter, and produces a clean level, single-cycle press/release pulses, and a press-toggled state suitable for driving an LED. An optional long-press detector can be compiled in. The block sits between a board pin and control logic.

---
 rtl/btn_pkg.sv | 19 +
 rtl/btn_sense_if.sv | 30 +++
 rtl/sync2.sv | 21 ++
 rtl/btn_sense.sv | 114 +++++++++++
 tb/tb_btn_sense.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// Shared constants and counter type for the push-button input path.
package btn_pkg;

  localparam int unsigned BTN_DB_CYCLES_DEF   = 32'd1048576;
  localparam int unsigned BTN_LONG_CYCLES_DEF = 32'd33554432;
  localparam int unsigned BTN_CNT_W           = 32;

  typedef logic [BTN_CNT_W-1:0] btn_cnt_t;

  // Both thresholds must be non-zero and reachable by a w-bit counter.
  function automatic bit btn_cfg_ok(input int unsigned db, input int unsigned lng,
                                    input int unsigned w);
    longint unsigned lim;
    lim = 64'd1 << w;
    return (w >= 1) && (w <= 32) && (db >= 1) && (lng >= 1) &&
           (longint'(db) < lim) && (longint'(lng) < lim);
  endfunction

endpackage

// File: rtl/btn_sense_if.sv
// Button pin and cleaned-up button events between a board pin and control logic.
interface btn_sense_if;

  logic btn;
  logic level;
  logic press;
  // "release" is a reserved word in SystemVerilog, hence the suffix.
  logic release_pulse;
  logic toggle;
  logic long_press;

  modport master (
    input  btn,
    output level,
    output press,
    output release_pulse,
    output toggle,
    output long_press
  );

  modport slave (
    output btn,
    input  level,
    input  press,
    input  release_pulse,
    input  toggle,
    input  long_press
  );

endinterface

// File: rtl/sync2.sv
// Generic two-flop synchroniser for a single asynchronous input, reset to 0.
module sync2 (
  input  logic m_clock,
  input  logic p_reset,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/btn_sense.sv
// Debounced push-button: clean level, press/release pulses and a press-toggled state.
// Long-press pulse output is compiled in only when BTN_LONGPRESS_EN is defined.
module btn_sense
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = BTN_DB_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES = BTN_LONG_CYCLES_DEF,
  parameter int unsigned CNT_W       = BTN_CNT_W
) (
  input logic         m_clock,
  input logic         p_reset,
  btn_sense_if.master bus
);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t DbLast = cnt_t'(DB_CYCLES - 1);

  // Elaborates only for an unusable parameter set, making it visible in the hierarchy.
  if (!btn_cfg_ok(DB_CYCLES, LONG_CYCLES, CNT_W)) begin : g_illegal_params
  end

  logic s2;

  sync2 u_sync (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .d       (bus.btn),
    .q       (s2)
  );

  cnt_t db_cnt_q, db_cnt_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic toggle_q, toggle_d;

  // Any return to the current level restarts the stability count.
  always_comb begin
    db_cnt_d  = db_cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    toggle_d  = toggle_q;
    if (s2 == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbLast) begin
      db_cnt_d  = '0;
      level_d   = s2;
      press_d   = s2;
      release_d = ~s2;
      if (s2) begin
        toggle_d = ~toggle_q;
      end
    end else begin
      db_cnt_d = db_cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
    end
  end

  assign bus.level         = level_q;
  assign bus.press         = press_q;
  assign bus.release_pulse = release_q;
  assign bus.toggle        = toggle_q;

`ifdef BTN_LONGPRESS_EN
  localparam cnt_t HoldMax = cnt_t'(LONG_CYCLES);

  cnt_t hold_cnt_q, hold_cnt_d;
  logic long_q, long_d;

  // Saturating at HoldMax gives exactly one pulse per hold.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    long_d     = 1'b0;
    if (!level_q) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q != HoldMax) begin
      hold_cnt_d = hold_cnt_q + cnt_t'(1);
      long_d     = (hold_cnt_d == HoldMax);
    end
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      hold_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      long_q     <= long_d;
    end
  end

  assign bus.long_press = long_q;
`else
  assign bus.long_press = 1'b0;
`endif

endmodule

// File: tb/tb_btn_sense.sv
// Scoreboard bench for btn_sense with DB_CYCLES=4, LONG_CYCLES=20.
module tb_btn_sense;

  localparam int DB   = 4;
  localparam int LONG = 20;

  logic m_clock = 1'b0;
  logic p_reset = 1'b0;

  btn_sense_if bus ();

  btn_sense #(
    .DB_CYCLES   (DB),
    .LONG_CYCLES (LONG),
    .CNT_W       (32)
  ) dut (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .bus     (bus)
  );

  always #5 m_clock = ~m_clock;

  // Edge counter: after posedge k, cyc == k until the next posedge.
  int cyc = 0;
  always @(posedge m_clock) cyc <= cyc + 1;

  typedef enum int {EvPress, EvRelease, EvLong} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       at;
    logic     tog;
  } ev_t;

  ev_t sb[$];
  int  checks   = 0;
  int  failures = 0;

  function automatic void push(input ev_kind_e kind, input int at, input logic tog);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    e.tog  = tog;
    sb.push_back(e);
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_pulse(input ev_kind_e kind, input logic exp_level);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s: pulse at cycle %0d, none expected", kind.name(), cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.at != cyc || bus.toggle !== e.tog || bus.level !== exp_level) begin
        failures++;
        $display("FAIL pulse_%s: got %s at %0d toggle=%b level=%b, expected %s at %0d toggle=%b level=%b",
                 e.kind.name(), kind.name(), cyc, bus.toggle, bus.level,
                 e.kind.name(), e.at, e.tog, exp_level);
      end
    end
  endtask

  // Monitor: any pulse pops the scoreboard; overdue entries count as missed.
  always @(negedge m_clock) begin
    while (sb.size() > 0 && sb[0].at < cyc) begin
      checks++;
      failures++;
      $display("FAIL missed_%s: no pulse, expected at cycle %0d (now %0d)",
               sb[0].kind.name(), sb[0].at, cyc);
      void'(sb.pop_front());
    end
    if (bus.press)         check_pulse(EvPress, 1'b1);
    if (bus.release_pulse) check_pulse(EvRelease, 1'b0);
    if (bus.long_press)    check_pulse(EvLong, 1'b1);
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge m_clock);
  endtask

  // Called at a negedge; the next posedge is the capture edge.
  task automatic set_btn(input logic v, output int cap);
    bus.btn = v;
    cap = cyc + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   cap;
    int   rise;
    int   fall;
    int   hold;
    int   rel_at;
    int   budget;
    logic exp_tog;

    bus.btn = 1'b0;
    p_reset = 1'b0;
    repeat (2) @(negedge m_clock);
    chk("reset_level", bus.level, 1'b0);
    chk("reset_press", bus.press, 1'b0);
    chk("reset_release", bus.release_pulse, 1'b0);
    chk("reset_toggle", bus.toggle, 1'b0);
    chk("reset_long", bus.long_press, 1'b0);
    p_reset = 1'b1;
    exp_tog = 1'b0;
    repeat (3) @(negedge m_clock);

    // First press with a long hold.
    set_btn(1'b1, cap);
    rise    = cap + DB + 1;
    exp_tog = 1'b1;
    push(EvPress, rise, exp_tog);
`ifdef BTN_LONGPRESS_EN
    push(EvLong, rise + LONG, exp_tog);
    hold = 30;
`else
    hold = 100;
`endif
    wait_until(rise + hold);
    chk("level_held", bus.level, 1'b1);
    set_btn(1'b0, cap);
    fall = cap + DB + 1;
    push(EvRelease, fall, exp_tog);
    wait_until(fall + 3);
    chk("level_after_release", bus.level, 1'b0);

    // Five 3-cycle glitches must be filtered out.
    for (int i = 0; i < 5; i++) begin
      set_btn(1'b1, cap);
      repeat (3) @(negedge m_clock);
      set_btn(1'b0, cap);
      repeat (4) @(negedge m_clock);
    end
    chk("glitch_level", bus.level, 1'b0);
    chk("glitch_toggle", bus.toggle, 1'b1);

    // Reset mid-count clears everything at once, including toggle.
    set_btn(1'b1, cap);
    repeat (4) @(negedge m_clock);
    p_reset = 1'b0;
    bus.btn = 1'b0;
    #1;
    chk("midreset_level", bus.level, 1'b0);
    chk("midreset_toggle", bus.toggle, 1'b0);
    chk("midreset_press", bus.press, 1'b0);
    exp_tog = 1'b0;
    @(negedge m_clock);
    p_reset = 1'b1;
    repeat (10) @(negedge m_clock);

    // Button already held when reset releases; short hold gives no long press.
    p_reset = 1'b0;
    bus.btn = 1'b1;
    @(negedge m_clock);
    p_reset = 1'b1;
    rise    = cyc + DB + 2;
    exp_tog = 1'b1;
    push(EvPress, rise, exp_tog);
    wait_until(rise + 9);
    set_btn(1'b0, cap);
    push(EvRelease, cap + DB + 1, exp_tog);
    wait_until(rise + LONG + 5);

    // Second press flips toggle back; again released before the long threshold.
    set_btn(1'b1, cap);
    rise    = cap + DB + 1;
    exp_tog = 1'b0;
    push(EvPress, rise, exp_tog);
    wait_until(rise + 9);
    set_btn(1'b0, cap);
    rel_at = cap + DB + 1;
    push(EvRelease, rel_at, exp_tog);
    wait_until(rise + LONG + 5);
    chk("second_press_toggle", bus.toggle, 1'b0);

    budget = 50;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge m_clock);
      budget--;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d events outstanding, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
